// File: rtl/mandel_dispatch.sv
// mandel_dispatch: walks a frame in raster order, launching the solver once per pixel
// and forwarding each iteration result to frame memory through a valid/ready write port.
module mandel_dispatch #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [26:0] i_cr_min,
  input  logic [26:0] i_ci_max,
  input  logic [26:0] i_dcr,
  input  logic [26:0] i_dci,
  input  logic [12:0] i_max_iter,
  output logic        o_solver_reset,
  output logic [26:0] o_solver_cr,
  output logic [26:0] o_solver_ci,
  output logic [12:0] o_solver_max_iter,
  input  logic [12:0] i_solver_iter,
  input  logic        i_solver_done,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [18:0] o_wr_addr,
  output logic [12:0] o_wr_data,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [31:0] o_frame_cycles
);
  typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, WAIT, WRITE, ADVANCE, DONE} state_t;
  state_t r_state, w_next;
  logic [15:0] r_x, r_y;
  logic [18:0] r_pix, r_addr;
  logic [26:0] r_cr_min, r_dcr, r_dci, r_cr, r_ci;
  logic [12:0] r_mi, r_data;
  logic [31:0] r_cnt, r_fc;
  logic w_last_x, w_last_y, w_go;
  assign w_last_x = r_x == 16'(H_PIXELS - 1);
  assign w_last_y = r_y == 16'(V_PIXELS - 1);
  assign w_go = r_state == IDLE && i_start;
  assign o_solver_cr = r_cr;
  assign o_solver_ci = r_ci;
  assign o_solver_max_iter = r_mi;
  assign o_wr_addr = r_addr;
  assign o_wr_data = r_data;
  assign o_frame_cycles = r_fc;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = LAUNCH;
      LAUNCH:  w_next = SETTLE;
      SETTLE:  w_next = WAIT;
      WAIT:    if (i_solver_done) w_next = WRITE;
      WRITE:   if (i_wr_ready) w_next = ADVANCE;
      ADVANCE: w_next = (w_last_x && w_last_y) ? DONE : LAUNCH;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    o_solver_reset = r_state == LAUNCH;
    o_wr_valid = r_state == WRITE;
    o_frame_done = r_state == DONE;
    o_busy = r_state != IDLE;
  end
  // r_pix tracks y*H_PIXELS+x incrementally since pixels are visited in raster order
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
      r_pix <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_cr_min <= '0;
      r_dcr <= '0;
      r_dci <= '0;
      r_cr <= '0;
      r_ci <= '0;
      r_mi <= '0;
      r_cnt <= '0;
      r_fc <= '0;
    end else begin
      if (w_go) begin
        r_cr_min <= i_cr_min;
        r_dcr <= i_dcr;
        r_dci <= i_dci;
        r_mi <= i_max_iter;
        r_cr <= i_cr_min;
        r_ci <= i_ci_max;
        r_x <= '0;
        r_y <= '0;
        r_pix <= '0;
      end
      if (r_state == WAIT && i_solver_done) begin
        r_data <= i_solver_iter;
        r_addr <= r_pix;
      end
      if (r_state == ADVANCE && !(w_last_x && w_last_y)) begin
        r_pix <= r_pix + 19'd1;
        r_x <= w_last_x ? '0 : r_x + 16'd1;
        r_y <= w_last_x ? r_y + 16'd1 : r_y;
        r_cr <= w_last_x ? r_cr_min : r_cr + r_dcr;
        r_ci <= w_last_x ? r_ci - r_dci : r_ci;
      end
      if (w_go) r_cnt <= '0;
      else if (r_state != IDLE && r_cnt != '1) r_cnt <= r_cnt + 32'd1;
      if (r_state == DONE) r_fc <= r_cnt;
    end
endmodule

// File: tb/tb_mandel_dispatch.sv
// tb_mandel_dispatch: drives frames through a stub solver and checks every cycle against
// a pixel-index model (coordinates from x*dcr / y*dci, address = data = raster index).
module tb_mandel_dispatch;
  localparam int H = 4, V = 3, N = H * V;
  logic clk = 0, rst_n = 0, start = 0;
  logic [26:0] cr_min = 0, ci_max = 0, dcr = 0, dci = 0;
  logic [12:0] max_iter = 0;
  logic s_reset, s_done, wr_valid, wr_ready = 0, busy, fdone;
  logic [26:0] s_cr, s_ci;
  logic [12:0] s_mi, s_iter, wr_data;
  logic [18:0] wr_addr;
  logic [31:0] fcyc;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mandel_dispatch #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cr_min(cr_min), .i_ci_max(ci_max),
    .i_dcr(dcr), .i_dci(dci), .i_max_iter(max_iter), .o_solver_reset(s_reset),
    .o_solver_cr(s_cr), .o_solver_ci(s_ci), .o_solver_max_iter(s_mi), .i_solver_iter(s_iter),
    .i_solver_done(s_done), .o_wr_valid(wr_valid), .i_wr_ready(wr_ready), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_busy(busy), .o_frame_done(fdone), .o_frame_cycles(fcyc));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // stub solver: result is the launch index within the frame, done `lat` cycles after launch
  int lat = 2, scnt = 0;
  bit stuck = 0;
  logic [12:0] lc = 0, st_iter = 0;
  logic sdone = 0;
  always @(posedge clk) begin
    if (!busy) lc <= 0;
    else if (s_reset) begin
      lc <= lc + 13'd1;
      st_iter <= lc;
    end
    if (s_reset) begin
      scnt <= lat;
      sdone <= 0;
    end else if (scnt > 1) scnt <= scnt - 1;
    else if (scnt == 1) begin
      scnt <= 0;
      sdone <= 1;
    end
  end
  assign s_iter = st_iter;
  assign s_done = sdone | stuck;
  bit mb = 0;
  int nl = 0, nw = 0, mcnt = 0, done_in = 0, n_fd = 0, addr6_cycles = 0;
  logic [31:0] fc_exp = 0;
  logic [26:0] p_cr, p_ci, p_dcr, p_dci;
  logic [12:0] p_mi;
  logic [26:0] cr_at [N];
  logic [26:0] ci_at [N];
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_solver_reset", 32'(s_reset), 0);
      chk("rst_wr_valid", 32'(wr_valid), 0);
      chk("rst_frame_done", 32'(fdone), 0);
      chk("rst_frame_cycles", fcyc, 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      mb = 0; nl = 0; nw = 0; done_in = 0; fc_exp = 0;
    end else begin
      if (mb) mcnt++;
      chk("busy", 32'(busy), 32'(mb));
      chk("frame_done", 32'(fdone), 32'(done_in == 1));
      chk("frame_cycles", fcyc, fc_exp);
      if (s_reset) begin
        chk("one_launch_per_pixel", nl, nw);
        chk("solver_cr", 32'(s_cr), 32'(27'(p_cr + 27'(nl % H) * p_dcr)));
        chk("solver_ci", 32'(s_ci), 32'(27'(p_ci - 27'(nl / H) * p_dci)));
        chk("solver_max_iter", 32'(s_mi), 32'(p_mi));
        if (nl < N) begin
          cr_at[nl] = s_cr;
          ci_at[nl] = s_ci;
        end
        nl++;
      end
      if (wr_valid) begin
        chk("wr_addr", 32'(wr_addr), nw);
        chk("wr_data", 32'(wr_data), nw);
        if (wr_addr == 6) addr6_cycles++;
        if (wr_ready) begin
          nw++;
          if (nw == N) done_in = 3;
        end
      end
      if (done_in > 0) done_in--;
      if (start && !mb) begin
        p_cr = cr_min; p_ci = ci_max; p_dcr = dcr; p_dci = dci; p_mi = max_iter;
        mb = 1; mcnt = 0; nl = 0; nw = 0;
      end
      if (fdone) begin
        n_fd++;
        fc_exp = mcnt - 1;
        mb = 0;
      end
    end
  end
  int mode = 0, stall_left = 0;
  bit spam = 0;
  task automatic tick();
    @(posedge clk);
    #1;
    start = 0;
    if (spam && busy) begin
      start = $urandom_range(0, 5) == 0;
      cr_min = 27'($urandom); ci_max = 27'($urandom); dcr = 27'($urandom); dci = 27'($urandom);
      max_iter = 13'($urandom);
    end
    if (mode == 1) wr_ready = $urandom_range(0, 2) != 0;
    else if (mode == 2 && wr_valid && wr_addr == 6 && stall_left > 0) begin
      wr_ready = 0;
      stall_left--;
    end else wr_ready = 1;
  endtask
  task automatic run_frame(input logic [26:0] a, b, c, d, input logic [12:0] m);
    int ok = 0;
    cr_min = a; ci_max = b; dcr = c; dci = d; max_iter = m;
    start = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (fdone) begin
        ok = 1;
        break;
      end
    end
    chk("frame_completes", ok, 1);
    tick();
    tick();
  endtask
  localparam logic [26:0] M2 = 27'h7000000, P1 = 27'h0800000, HALF = 27'h0400000;
  int fd0, a6;
  initial begin
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("idle_busy", 32'(busy), 0);
    fd0 = n_fd;
    run_frame(M2, P1, HALF, HALF, 13'd100);
    chk("A_frame_done_count", n_fd - fd0, 1);
    chk("A_writes", nw, N);
    chk("A_launches", nl, N);
    chk("A_frame_cycles", fcyc, 72);
    chk("A_cr_3_2", 32'(cr_at[11]), 32'h7C00000);
    chk("A_ci_3_2", 32'(ci_at[11]), 0);
    chk("A_cr_0_1", 32'(cr_at[4]), 32'h7000000);
    chk("A_busy_after", 32'(busy), 0);
    mode = 2; stall_left = 5; a6 = addr6_cycles;
    run_frame(M2, P1, HALF, HALF, 13'd100);
    chk("B_stall_hold_cycles", addr6_cycles - a6, 6);
    chk("B_frame_cycles", fcyc, 77);
    mode = 0; stuck = 1;
    run_frame(M2, P1, HALF, HALF, 13'd7);
    chk("C1_frame_cycles", fcyc, 60);
    chk("C1_launches", nl, N);
    run_frame(M2, P1, HALF, HALF, 13'd7);
    chk("C2_frame_cycles", fcyc, 60);
    stuck = 0;
    fd0 = n_fd;
    cr_min = M2; ci_max = P1; dcr = HALF; dci = HALF; max_iter = 13'd9;
    start = 1;
    for (int i = 0; i < 200 && nl < 6; i++) tick();
    chk("abort_reached_pixel5", 32'(nl >= 6), 1);
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    chk("abort_no_frame_done", n_fd - fd0, 0);
    chk("abort_cycles_cleared", fcyc, 0);
    run_frame(M2, P1, HALF, HALF, 13'd9);
    chk("abort_restart_done", n_fd - fd0, 1);
    chk("abort_restart_cycles", fcyc, 72);
    mode = 1; spam = 1;
    for (int f = 0; f < 6; f++) begin
      lat = $urandom_range(1, 4);
      fd0 = n_fd;
      run_frame(27'($urandom), 27'($urandom), 27'($urandom), 27'($urandom), 13'($urandom));
      chk("R_one_frame_done", n_fd - fd0, 1);
      chk("R_writes", nw, N);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mandel_dispatch.md
MANDEL_DISPATCH -- requirements
Module: mandel_dispatch

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL provide parameter H_PIXELS, default 640, pixels per row.
REQ-003 SHALL provide parameter V_PIXELS, default 480, rows per frame.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  async active-low reset.
REQ-006 start  in  1  one-cycle frame request; ignored while busy=1.
REQ-007 cr_min  in  27  signed 4.23 real coordinate of column 0.
REQ-008 ci_max  in  27  signed 4.23 imaginary coordinate of row 0.
REQ-009 dcr  in  27  signed 4.23 real step per column.
REQ-010 dci  in  27  signed 4.23 imaginary step per row (subtracted).
REQ-011 max_iter  in  13  iteration cap forwarded to solver.
REQ-012 solver_reset  out  1  active-high launch pulse to solver.
REQ-013 solver_cr  out  27  current pixel real coordinate.
REQ-014 solver_ci  out  27  current pixel imaginary coordinate.
REQ-015 solver_max_iter  out  13  latched max_iter.
REQ-016 solver_iter  in  13  solver iteration result.
REQ-017 solver_done  in  1  solver result valid level.
REQ-018 wr_valid  out  1  pixel write request to frame memory.
REQ-019 wr_ready  in  1  memory accepts write when wr_valid&wr_ready.
REQ-020 wr_addr  out  19  y*H_PIXELS+x.
REQ-021 wr_data  out  13  captured solver_iter.
REQ-022 busy  out  1  high from start acceptance until frame_done.
REQ-023 frame_done  out  1  one-cycle pulse after last pixel write.
REQ-024 frame_cycles  out  32  clk cycles of last completed frame.

Function
REQ-025 FSM states SHALL be IDLE, LAUNCH, SETTLE, WAIT, WRITE, ADVANCE, DONE.
REQ-026 IDLE: on start=1, latch cr_min, ci_max, dcr, dci, max_iter; x=0, y=0, solver_cr=cr_min, solver_ci=ci_max, frame counter cleared; go LAUNCH.
REQ-027 LAUNCH: solver_reset=1 exactly one cycle; -> SETTLE.
REQ-028 SETTLE: one cycle, solver_done ignored (stale-done guard); -> WAIT.
REQ-029 WAIT: when solver_done=1, capture solver_iter into wr_data, wr_addr=y*H_PIXELS+x; -> WRITE; no timeout.
REQ-030 WRITE: wr_valid=1, wr_addr/wr_data stable until wr_ready=1 sampled; then wr_valid=0 next cycle, -> ADVANCE.
REQ-031 ADVANCE: if x<H_PIXELS-1: x+=1, solver_cr+=dcr, -> LAUNCH; else if y<V_PIXELS-1: x=0, y+=1, solver_cr=cr_min, solver_ci-=dci, -> LAUNCH; else -> DONE.
REQ-032 DONE: frame_done=1 one cycle, frame_cycles=counter, busy=0 next cycle; -> IDLE.
REQ-033 Coordinate add/subtract SHALL be 27-bit two's-complement, wrapping, no saturation.
REQ-034 Frame counter SHALL increment every cycle in non-IDLE states, saturating at 2^32-1.
REQ-035 start during busy=1 SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-036 wr_ready asserted outside WRITE SHALL have no effect; solver_done outside WAIT SHALL be ignored.
REQ-037 Latched inputs SHALL not change mid-frame regardless of input activity.

Reset
REQ-038 reset=0 SHALL asynchronously force IDLE, all outputs 0 (solver_reset=0, wr_valid=0, busy=0, frame_done=0, frame_cycles=0), x=y=0.
REQ-039 Reset mid-frame SHALL abandon the frame with no frame_done; next start begins at pixel (0,0).

Verification (bench H_PIXELS=4, V_PIXELS=3, stub solver: done two cycles after launch, iter=x+4y)
REQ-040 start, cr_min=-2.0, dcr=0.5, ci_max=1.0, dci=0.5, wr_ready=1 -> 12 writes, addr 0..11 in order, data=addr, one frame_done, busy low after.
REQ-041 Pixel (3,2) launch -> solver_cr=-0.5 (0x7C00000), solver_ci=0.0; pixel (0,1) -> solver_cr=-2.0.
REQ-042 wr_ready low 5 cycles at pixel 6 -> wr_valid held, addr=6/data=6 stable, no relaunch until accepted.
REQ-043 Stub solver_done stuck high -> SETTLE ignores it; each pixel still takes exactly one LAUNCH pulse; frame_cycles identical run-to-run.
REQ-044 reset low at pixel 5 then start -> no frame_done for aborted frame; writes restart at addr 0.
REQ-045 start pulses mid-frame -> ignored; exactly 12 writes and one frame_done.
